// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and data access
//
// Ports:
//   CLK, RST                        clock, asynchronous active-low reset
//   if_req/if_addr                  fetch request (held until if_done)
//   if_done/if_rdata                fetch completion pulse and registered fetched word
//   d_req/d_addr/d_we/d_wdata/d_ctrl  data request (held until d_done)
//   d_done/d_rdata                  data completion pulse and registered load data
//   mem_en/mem_we/mem_addr/mem_wdata/mem_ctrl  shared memory port, driven only while BUSY
//   mem_rdata                       memory read data, valid in the last mem_en cycle
//   owner                           0 = fetch, 1 = data; owner of current/last transaction
//   busy                            high while a transaction is in flight (BUSY or RESP)
module mem_port_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int MAX_CONSEC = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic        d_we,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_ctrl,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_ctrl,
    input  logic [31:0] mem_rdata,
    output logic        owner,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT_LOAD  = 4'(MEM_LAT - 1);
    localparam logic [3:0] STARV_MAX = 4'(MAX_CONSEC);
    localparam logic [2:0] CTRL_WORD = 3'b010;

    state_t      state, state_nxt;
    logic [3:0]  wait_cnt;
    logic [3:0]  starv_cnt;
    logic        grant;
    logic        grant_data;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [2:0]  lat_ctrl;

    // Arbitration happens only in IDLE; fetch overrides data priority once
    // it has waited through MAX_CONSEC consecutive data grants.
    always_comb begin
        state_nxt  = state;
        grant      = 1'b0;
        grant_data = 1'b0;
        case (state)
            IDLE: begin
                if (d_req || if_req) begin
                    grant      = 1'b1;
                    grant_data = d_req && !(if_req && (starv_cnt == STARV_MAX));
                    state_nxt  = BUSY;
                end
            end
            BUSY: begin
                if (wait_cnt == 4'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            starv_cnt <= '0;
            owner     <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_ctrl  <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                owner     <= grant_data;
                lat_we    <= grant_data ? d_we : 1'b0;
                lat_addr  <= grant_data ? d_addr : if_addr;
                lat_wdata <= grant_data ? d_wdata : 32'd0;
                lat_ctrl  <= grant_data ? d_ctrl : CTRL_WORD;
                wait_cnt  <= LAT_LOAD;
                // Only data grants that made a waiting fetch wait count toward starvation.
                if (grant_data && if_req) begin
                    if (starv_cnt != STARV_MAX) begin
                        starv_cnt <= starv_cnt + 4'd1;
                    end
                end else begin
                    starv_cnt <= '0;
                end
            end else if (state == BUSY) begin
                if (wait_cnt != 4'd0) begin
                    wait_cnt <= wait_cnt - 4'd1;
                end else if (!owner) begin
                    if_rdata <= mem_rdata;
                end else if (!lat_we) begin
                    d_rdata <= mem_rdata;
                end
            end
        end
    end

    // Port outputs are gated by state so the bus reads zero outside BUSY.
    assign mem_en    = (state == BUSY);
    assign mem_we    = mem_en && lat_we;
    assign mem_addr  = mem_en ? lat_addr : 32'd0;
    assign mem_wdata = mem_en ? lat_wdata : 32'd0;
    assign mem_ctrl  = mem_en ? lat_ctrl : 3'd0;
    assign if_done   = (state == RESP) && !owner;
    assign d_done    = (state == RESP) && owner;
    assign busy      = (state != IDLE);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Multi-cycle arbiter and sequencer that shares one unified memory port between two requesters: instruction fetch and data load/store. It replaces separate imem/dmem access for the planned multi-cycle/pipelined core variant. It serialises accesses, holds the memory port for a fixed latency, then returns a one-cycle done pulse with read data to the winning requester. Data has priority; a starvation guard forces fetch through after a bounded run of data grants.

Parameters:
MEM_LAT, 2, memory access latency in cycles (legal 1..15); mem_en is held this many cycles per access.
MAX_CONSEC, 4, max consecutive data grants while fetch is waiting (legal 1..15).

Ports:
CLK  in  1  clock; all state changes on rising edge.
RST  in  1  asynchronous active-low reset.
if_req  in  1  fetch request; held until if_done.
if_addr  in  32  fetch address.
if_done  out  1  one-cycle pulse; fetch complete, if_rdata valid.
if_rdata  out  32  fetched word (registered).
d_req  in  1  data request; held until d_done.
d_addr  in  32  data address.
d_we  in  1  1 = store, 0 = load.
d_wdata  in  32  store data.
d_ctrl  in  3  size/sign code, passed to memory (dmem_ctrl encoding).
d_done  out  1  one-cycle pulse; data access complete.
d_rdata  out  32  load data (registered).
mem_en  out  1  memory port active.
mem_we  out  1  memory write enable.
mem_addr  out  32  memory address.
mem_wdata  out  32  memory write data.
mem_ctrl  out  3  memory size code; fetch always drives 3'b010 (word).
mem_rdata  in  32  memory read data; valid in the last mem_en cycle.
owner  out  1  0 = fetch, 1 = data; owner of the current/last transaction.
busy  out  1  high in BUSY and RESP.

Behaviour:
- Reset (RST=0, async): state IDLE; every output 0, including rdata registers and owner; wait counter and starvation counter cleared. A transaction in flight is abandoned with no done pulse. Requesters must re-request.
- States: IDLE, BUSY, RESP.
- IDLE, no req: stay IDLE. Memory outputs 0.
- IDLE, arbitration: only d_req -> data wins; only if_req -> fetch wins.
  - Both requesting: data wins unless starv_cnt == MAX_CONSEC, in which case fetch wins.
  - On any grant: latch addr/we/wdata/ctrl of the winner into internal registers (we=0 and ctrl=3'b010 for fetch), set owner, load wait_cnt = MEM_LAT-1, go to BUSY.
- Starvation counter:
  - Data grant while if_req=1: +1, saturating at MAX_CONSEC.
  - Fetch grant, or any grant with if_req=0: cleared.
- BUSY: mem_en=1; mem_we/mem_addr/mem_wdata/mem_ctrl come from the latched registers and are stable for all MEM_LAT cycles.
  - wait_cnt != 0: decrement and stay in BUSY.
  - wait_cnt == 0: capture mem_rdata into if_rdata or d_rdata per owner (loads/fetches only; stores leave d_rdata unchanged), go to RESP.
- RESP: mem_en=0; pulse if_done or d_done per owner for exactly one cycle; go to IDLE.
- Timing: a request first seen in IDLE at cycle 0 gives mem_en in cycles 1..MEM_LAT and done in cycle MEM_LAT+1. The next arbitration is at MEM_LAT+2, so back-to-back access period is MEM_LAT+2.
- req is sampled only in IDLE. Changes to req or inputs during BUSY/RESP are ignored, and a dropped req does not abort the transaction. A requester that sees done must present its next request (or drop req) in the following cycle. A req still high in the IDLE cycle after RESP is treated as a new request.
- if_done and d_done are never high in the same cycle.
- Addresses pass through unmodified (no alignment check).

Test Plan:
- Reset/idle: RST=0 mid-BUSY -> all outputs 0 immediately; after RST=1 with no req -> state IDLE, mem_en=0 indefinitely.
- Single fetch, MEM_LAT=2: if_req=1, if_addr=0x100 at cycle 0; mem_rdata=0x00500093 in cycle 2 -> mem_en high cycles 1-2, mem_addr=0x100, mem_ctrl=3'b010, if_done cycle 3, if_rdata=0x00500093.
- Store then load: d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_ctrl=3'b010 -> mem_we=1 for 2 cycles, d_done pulse, d_rdata unchanged. Then a load from 0x2000 with memory returning 0xDEADBEEF -> d_rdata=0xDEADBEEF.
- Simultaneous requests: if_req and d_req both held -> data granted first (owner=1), fetch next. Done pulses alternate, never overlapping.
- Starvation, MAX_CONSEC=4: d_req and if_req held continuously, data re-requesting immediately -> 4 data transactions, then 1 fetch, then the pattern repeats. starv_cnt returns to 0 after the fetch grant.
- Req drop mid-BUSY: d_req deasserted in cycle 1 -> transaction still completes, d_done pulses at cycle MEM_LAT+1, no new grant follows.
